gen_teamplayer: RTL and testbench

- Sega Team Player (4-way multitap) protocol controller for one control port of gen_io.
- Sequences up to four pads onto that port's 7-bit data lines.
- Sits between gen_io's port data/control registers (host-driven TH/TR bits) and the MiSTer joystick inputs.
- Replaces pad_io on the selected port when multitap mode is enabled; gen_io muxes its DO in place of PAD1_DO/PAD2_DO.

---
 rtl/gen_io_pkg.sv | 25 ++
 rtl/teamplayer_nib_sel.sv | 49 ++++
 rtl/gen_teamplayer.sv | 153 +++++++++++++++
 tb/tb_gen_teamplayer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gen_io_pkg.sv
// Shared constants and types for the gen_io Team Player multitap.
// Holds the nibble codes, header length and the tap FSM state enum.
package gen_io_pkg;

    localparam logic [3:0] TAP_ID    = 4'h3;
    localparam logic [3:0] TYPE_3BTN = 4'h0;
    localparam logic [3:0] TYPE_6BTN = 4'h1;
    localparam logic [3:0] TYPE_NONE = 4'hF;
    localparam logic [4:0] HDR_LEN   = 5'd7;
    localparam logic [4:0] MAX_IDX   = 5'd19;

    typedef enum logic {
        IDLE,
        SEQ
    } tap_state_t;

    function automatic logic [3:0] pad_type(input logic p, input logic s);
        return !p ? TYPE_NONE : (s ? TYPE_6BTN : TYPE_3BTN);
    endfunction

    function automatic logic [4:0] pad_len(input logic p, input logic s);
        return !p ? 5'd0 : (s ? 5'd3 : 5'd2);
    endfunction

endpackage

// File: rtl/teamplayer_nib_sel.sv
// Maps a nibble index and the latched pad snapshot to the nibble
// the Team Player presents on the data lines at that position.
module teamplayer_nib_sel
    import gen_io_pkg::*;
(
    input  logic [4:0]  idx,
    input  logic [3:0]  present,
    input  logic [3:0]  six_btn,
    input  logic [47:0] pad_btn,
    output logic [3:0]  nib
);

    // Header, then payload of present pads packed back to back.
    always_comb begin
        logic [4:0]  base;
        logic [4:0]  len;
        logic [4:0]  rel;
        logic [1:0]  pi;
        logic [11:0] b;
        nib  = TYPE_NONE;
        base = HDR_LEN;
        len  = '0;
        rel  = '0;
        pi   = 2'(idx - 5'd3);
        b    = '1;
        unique case (1'b1)
            (idx == 5'd0): nib = TYPE_NONE;
            (idx == 5'd1 || idx == 5'd2): nib = 4'h0;
            (idx >= 5'd3 && idx < HDR_LEN):
                nib = pad_type(present[pi], six_btn[pi]);
            default: begin
                for (int n = 0; n < 4; n++) begin
                    len = pad_len(present[n], six_btn[n]);
                    if (idx >= base && idx < base + len) begin
                        rel = idx - base;
                        b   = pad_btn[n*12 +: 12];
                        unique case (rel[1:0])
                            2'd0:    nib = b[3:0];
                            2'd1:    nib = b[7:4];
                            default: nib = {b[8], b[9], b[10], b[11]};
                        endcase
                    end
                    base = base + len;
                end
            end
        endcase
    end

endmodule

// File: rtl/gen_teamplayer.sv
// Sega Team Player protocol controller for one gen_io control port.
// Handshakes TH/TR from the host and sequences up to four pads.
module gen_teamplayer
    import gen_io_pkg::*;
#(
    parameter int ACK_DELAY = 24,
    parameter int TIMEOUT   = 11600
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CE,
    input  logic        TH_IN,
    input  logic        TR_IN,
    input  logic [3:0]  PRESENT,
    input  logic [3:0]  SIX_BTN,
    input  logic [47:0] PAD_BTN,
    output logic [7:0]  DO,
    output logic        BUSY
);

    localparam int DW = $clog2(ACK_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DLY_LOAD = DW'(ACK_DELAY - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    tap_state_t    state, state_nx;
    logic          th_d, tr_d;
    logic [4:0]    idx, idx_nx;
    logic          tl, tl_nx;
    logic [3:0]    nib, nib_nx;
    logic [DW-1:0] dly, dly_nx;
    logic          pend, pend_nx;
    logic          dly_tl, dly_tl_nx;
    logic [TW-1:0] to_cnt, to_nx;
    logic [3:0]    s_pres, s_pres_nx;
    logic [3:0]    s_six, s_six_nx;
    logic [47:0]   s_btn, s_btn_nx;
    logic [3:0]    sel_nib;
    logic          th_fall, th_rise, tr_edge;

    teamplayer_nib_sel u_sel (
        .idx     (idx),
        .present (s_pres),
        .six_btn (s_six),
        .pad_btn (s_btn),
        .nib     (sel_nib)
    );

    assign th_fall = th_d & ~TH_IN;
    assign th_rise = ~th_d & TH_IN;
    assign tr_edge = tr_d ^ TR_IN;

    assign DO   = {1'b0, TH_IN, TR_IN, tl, nib};
    assign BUSY = (state == SEQ);

    // State, counters and snapshot advance only on clock enable.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            th_d   <= 1'b1;
            tr_d   <= 1'b1;
            idx    <= '0;
            tl     <= 1'b1;
            nib    <= TAP_ID;
            dly    <= '0;
            pend   <= 1'b0;
            dly_tl <= 1'b1;
            to_cnt <= '0;
            s_pres <= '1;
            s_six  <= '1;
            s_btn  <= '1;
        end else if (CE) begin
            state  <= state_nx;
            th_d   <= TH_IN;
            tr_d   <= TR_IN;
            idx    <= idx_nx;
            tl     <= tl_nx;
            nib    <= nib_nx;
            dly    <= dly_nx;
            pend   <= pend_nx;
            dly_tl <= dly_tl_nx;
            to_cnt <= to_nx;
            s_pres <= s_pres_nx;
            s_six  <= s_six_nx;
            s_btn  <= s_btn_nx;
        end
    end

    // Next state: TH rise beats TR edge, which beats timeout and expiry.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        tl_nx     = tl;
        nib_nx    = nib;
        dly_nx    = dly;
        pend_nx   = pend;
        dly_tl_nx = dly_tl;
        to_nx     = to_cnt;
        s_pres_nx = s_pres;
        s_six_nx  = s_six;
        s_btn_nx  = s_btn;
        unique case (state)
            IDLE: begin
                nib_nx  = TAP_ID;
                tl_nx   = 1'b1;
                pend_nx = 1'b0;
                to_nx   = '0;
                if (th_fall) begin
                    state_nx  = SEQ;
                    idx_nx    = '0;
                    nib_nx    = TYPE_NONE;
                    tl_nx     = TR_IN;
                    s_pres_nx = PRESENT;
                    s_six_nx  = SIX_BTN;
                    s_btn_nx  = PAD_BTN;
                end
            end
            default: begin
                if (th_rise) begin
                    state_nx = IDLE;
                    nib_nx   = TAP_ID;
                    tl_nx    = 1'b1;
                    pend_nx  = 1'b0;
                    to_nx    = '0;
                end else if (tr_edge) begin
                    idx_nx    = (idx == 5'd31) ? idx : idx + 5'd1;
                    dly_nx    = DLY_LOAD;
                    pend_nx   = 1'b1;
                    dly_tl_nx = TR_IN;
                    to_nx     = '0;
                end else if (to_cnt == TO_LAST) begin
                    idx_nx  = '0;
                    nib_nx  = TYPE_NONE;
                    tl_nx   = TR_IN;
                    pend_nx = 1'b0;
                    to_nx   = '0;
                end else begin
                    to_nx = to_cnt + 1'b1;
                    if (pend) begin
                        if (dly == '0) begin
                            nib_nx  = sel_nib;
                            tl_nx   = dly_tl;
                            pend_nx = 1'b0;
                        end else begin
                            dly_nx = dly - 1'b1;
                        end
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_gen_teamplayer.sv
// Directed bench for gen_teamplayer: nibble tables per pad mix,
// plus hand sequences for coalesced edges, CE gating, timeout, reset.
module tb_gen_teamplayer;

    localparam int AD = 24;
    localparam int TO = 11600;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CE;
    logic        TH_IN;
    logic        TR_IN;
    logic [3:0]  PRESENT;
    logic [3:0]  SIX_BTN;
    logic [47:0] PAD_BTN;
    logic [7:0]  DO;
    logic        BUSY;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0]       present;
        logic [3:0]       six;
        logic [47:0]      btn;
        int               n_edges;
        logic [19:0][3:0] exp;
    } vec_t;

    vec_t vecs [4];

    gen_teamplayer #(
        .ACK_DELAY (AD),
        .TIMEOUT   (TO)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CE      (CE),
        .TH_IN   (TH_IN),
        .TR_IN   (TR_IN),
        .PRESENT (PRESENT),
        .SIX_BTN (SIX_BTN),
        .PAD_BTN (PAD_BTN),
        .DO      (DO),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, got, want);
    endtask

    function automatic logic [7:0] dx(input logic th, input logic tr,
                                      input logic tl, input logic [3:0] n);
        return {1'b0, th, tr, tl, n};
    endfunction

    task automatic start_seq(input vec_t v);
        PRESENT = v.present;
        SIX_BTN = v.six;
        PAD_BTN = v.btn;
        TH_IN   = 1'b1;
        TR_IN   = 1'b1;
        tick(3);
        TH_IN = 1'b0;
        tick(1);
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        logic [3:0] cur;
        logic       tl;
        start_seq(v);
        chk($sformatf("v%0d_fall", vi), DO, dx(0, TR_IN, TR_IN, 4'hF));
        chk($sformatf("v%0d_busy", vi), {7'b0, BUSY}, 8'h01);
        PRESENT = ~v.present;
        SIX_BTN = ~v.six;
        PAD_BTN = ~v.btn;
        cur = 4'hF;
        tl  = TR_IN;
        for (int k = 1; k <= v.n_edges; k++) begin
            TR_IN = ~TR_IN;
            tick(AD);
            chk($sformatf("v%0d_hold%0d", vi, k), DO, dx(0, TR_IN, tl, cur));
            tick(1);
            cur = v.exp[k-1];
            tl  = TR_IN;
            chk($sformatf("v%0d_nib%0d", vi, k), DO, dx(0, TR_IN, tl, cur));
            tick(6);
        end
        TH_IN = 1'b1;
        tick(1);
        chk($sformatf("v%0d_rise", vi), DO, dx(1, TR_IN, 1, 4'h3));
        chk($sformatf("v%0d_idle", vi), {7'b0, BUSY}, 8'h00);
    endtask

    initial begin
        logic tl0;

        vecs[0].present = 4'hF;
        vecs[0].six     = 4'h0;
        vecs[0].btn     = 48'hFFF_FFF_FFF_FFE;
        vecs[0].n_edges = 15;
        vecs[0].exp     = 80'hFFFFFFFFFFFFFE000000;
        vecs[1].present = 4'b0101;
        vecs[1].six     = 4'b0001;
        vecs[1].btn     = 48'h000_F96_000_E21;
        vecs[1].n_edges = 15;
        vecs[1].exp     = 80'hFFFFFFFFF96721F0F100;
        vecs[2].present = 4'b1110;
        vecs[2].six     = 4'b1000;
        vecs[2].btn     = 48'h8CB_05A_034_123;
        vecs[2].n_edges = 15;
        vecs[2].exp     = 80'hFFFFFFF1CB5A34100F00;
        vecs[3].present = 4'hF;
        vecs[3].six     = 4'hF;
        vecs[3].btn     = 48'h0BA_987_654_321;
        vecs[3].n_edges = 20;
        vecs[3].exp     = 80'hFF0BA987654C21111100;

        RESET_N = 1'b0;
        CE      = 1'b1;
        TH_IN   = 1'b1;
        TR_IN   = 1'b1;
        PRESENT = '0;
        SIX_BTN = '0;
        PAD_BTN = '0;
        tick(3);
        chk("rst_do", DO, 8'h73);
        chk("rst_busy", {7'b0, BUSY}, 8'h00);
        RESET_N = 1'b1;
        tick(2);
        chk("idle_do", DO, 8'h73);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        start_seq(vecs[1]);
        tl0 = TR_IN;
        TR_IN = ~TR_IN;
        tick(5);
        TR_IN = ~TR_IN;
        tick(20);
        chk("dbl_first", DO, dx(0, TR_IN, tl0, 4'hF));
        tick(4);
        chk("dbl_hold", DO, dx(0, TR_IN, tl0, 4'hF));
        tick(1);
        chk("dbl_upd", DO, dx(0, TR_IN, TR_IN, 4'h0));
        TR_IN = ~TR_IN;
        tick(AD + 1);
        chk("dbl_idx3", DO, dx(0, TR_IN, TR_IN, 4'h1));
        TR_IN = ~TR_IN;
        tick(10);
        TH_IN = 1'b1;
        tick(1);
        chk("pend_rise", DO, dx(1, TR_IN, 1, 4'h3));
        chk("pend_busy", {7'b0, BUSY}, 8'h00);
        tick(30);
        chk("pend_late", DO, dx(1, TR_IN, 1, 4'h3));

        start_seq(vecs[1]);
        tl0 = TR_IN;
        CE = 1'b0;
        TR_IN = ~TR_IN;
        tick(40);
        chk("ce_off", DO, dx(0, TR_IN, tl0, 4'hF));
        CE = 1'b1;
        tick(AD);
        chk("ce_hold", DO, dx(0, TR_IN, tl0, 4'hF));
        tick(1);
        chk("ce_upd", DO, dx(0, TR_IN, TR_IN, 4'h0));
        TH_IN = 1'b1;
        tick(1);

        start_seq(vecs[1]);
        for (int k = 1; k <= 5; k++) begin
            TR_IN = ~TR_IN;
            tick(AD + 1);
            tick(6);
        end
        chk("to_pre5", DO, dx(0, TR_IN, TR_IN, vecs[1].exp[4]));
        tick(TO - 31);
        chk("to_edge", DO, dx(0, TR_IN, TR_IN, vecs[1].exp[4]));
        tick(1);
        chk("to_fire", DO, dx(0, TR_IN, TR_IN, 4'hF));
        chk("to_busy", {7'b0, BUSY}, 8'h01);
        TR_IN = ~TR_IN;
        tick(AD + 1);
        chk("to_idx1", DO, dx(0, TR_IN, TR_IN, 4'h0));
        tick(3);
        RESET_N = 1'b0;
        #1;
        chk("arst_do", DO, dx(0, TR_IN, 1, 4'h3));
        chk("arst_busy", {7'b0, BUSY}, 8'h00);
        tick(2);
        RESET_N = 1'b1;
        TH_IN = 1'b1;
        tick(2);
        chk("end_do", DO, dx(1, TR_IN, 1, 4'h3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
